// File: rtl/bcd_seven_seg_scan_if.sv
// Display bus for the BCD scan driver: load strobe, packed BCD in,
// and the active-low anode/segment/dp outputs plus status flags.
interface bcd_seven_seg_scan_if;
  logic        load;
  logic [11:0] bcd_in;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        pending;
  logic        frame_tick;

  modport master (
    output load, bcd_in,
    input  an, seg, dp, pending, frame_tick
  );

  modport slave (
    input  load, bcd_in,
    output an, seg, dp, pending, frame_tick
  );
endinterface

// File: rtl/bcd_seven_seg_scan.sv
// 4-slot common-anode scan driver for a packed 3-digit BCD value.
// Ports: clk, reset (sync, high), bus (slave: load/bcd_in in; an/seg/dp/pending/frame_tick out).
module bcd_seven_seg_scan #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic                 clk,
  input  logic                 reset,
  bcd_seven_seg_scan_if.slave  bus
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] CMAX = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    S_ONES,
    S_TENS,
    S_HUND,
    S_BLANK
  } slot_t;

  slot_t         slot, slot_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [11:0]   pend_val, shown_val;
  logic          pend_q;
  logic          wrap_q;
  logic          tick_q;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          last, boundary;
  logic [3:0]    hun, ten, one;

  function automatic logic [6:0] dec7(input logic [3:0] d);
    case (d)
      4'd0:    dec7 = 7'b1000000;
      4'd1:    dec7 = 7'b1111001;
      4'd2:    dec7 = 7'b0100100;
      4'd3:    dec7 = 7'b0110000;
      4'd4:    dec7 = 7'b0011001;
      4'd5:    dec7 = 7'b0010010;
      4'd6:    dec7 = 7'b0000010;
      4'd7:    dec7 = 7'b1111000;
      4'd8:    dec7 = 7'b0000000;
      4'd9:    dec7 = 7'b0010000;
      default: dec7 = 7'b0111111;
    endcase
  endfunction

  assign hun = shown_val[11:8];
  assign ten = shown_val[7:4];
  assign one = shown_val[3:0];

  always_comb begin
    last     = (cnt == CMAX);
    boundary = last && (slot == S_BLANK);
    cnt_nxt  = last ? '0 : cnt + CW'(1);
    slot_nxt = slot;
    if (last)
      slot_nxt = slot_t'(slot + 2'd1);
    an_d  = 4'b1111;
    seg_d = 7'b1111111;
    unique case (slot)
      S_ONES: begin
        an_d  = 4'b1110;
        seg_d = dec7(one);
      end
      S_TENS: begin
        if (hun != 4'd0 || ten != 4'd0) begin
          an_d  = 4'b1101;
          seg_d = dec7(ten);
        end
      end
      S_HUND: begin
        if (hun != 4'd0) begin
          an_d  = 4'b1011;
          seg_d = dec7(hun);
        end
      end
      S_BLANK: begin
        an_d  = 4'b1111;
        seg_d = 7'b1111111;
      end
    endcase
  end

  // The tick is delayed a second cycle so it lines up with the
  // first registered slot-0 output of the new frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      slot      <= S_ONES;
      pend_val  <= '0;
      shown_val <= '0;
      pend_q    <= 1'b0;
      wrap_q    <= 1'b0;
      tick_q    <= 1'b0;
      an_q      <= 4'b1111;
      seg_q     <= 7'b1111111;
    end else begin
      cnt    <= cnt_nxt;
      slot   <= slot_nxt;
      wrap_q <= boundary;
      tick_q <= wrap_q;
      an_q   <= an_d;
      seg_q  <= seg_d;
      if (boundary && pend_q) begin
        shown_val <= pend_val;
        pend_q    <= 1'b0;
      end
      // A load on the boundary cycle re-arms pending after the swap.
      if (bus.load) begin
        pend_val <= bus.bcd_in;
        pend_q   <= 1'b1;
      end
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = 1'b1;
  assign bus.pending    = pend_q;
  assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_bcd_seven_seg_scan.sv
// Bench for bcd_seven_seg_scan: cycle-position model plus directed
// literal checks of scan order, blanking, dash, and frame-boundary loads.
module tb_bcd_seven_seg_scan;
  localparam int D = 4;
  localparam int F = 4 * D;

  logic clk = 1'b0;
  logic reset;

  bcd_seven_seg_scan_if bus ();

  bcd_seven_seg_scan #(.REFRESH_DIV(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  logic [6:0] tab [0:15] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
    7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
  };

  int          pos = 0;
  logic        mvalid = 1'b0;
  logic [11:0] m_pend, m_shown;
  logic        m_pf;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_pf, e_ft;

  // pos = edges since reset release; outputs after an edge describe
  // the slot that the pre-edge position falls in.
  always @(posedge clk) begin
    int s, h, t, o;
    if (reset) begin
      mvalid  = 1'b1;
      pos     = 0;
      m_pend  = '0;
      m_shown = '0;
      m_pf    = 1'b0;
      e_an    = 4'b1111;
      e_seg   = 7'b1111111;
      e_pf    = 1'b0;
      e_ft    = 1'b0;
    end else if (mvalid) begin
      s = (pos / D) % 4;
      h = int'(m_shown[11:8]);
      t = int'(m_shown[7:4]);
      o = int'(m_shown[3:0]);
      e_an  = 4'b1111;
      e_seg = 7'b1111111;
      if (s == 0) begin
        e_an  = 4'b1110;
        e_seg = tab[o];
      end else if (s == 1 && (h != 0 || t != 0)) begin
        e_an  = 4'b1101;
        e_seg = tab[t];
      end else if (s == 2 && h != 0) begin
        e_an  = 4'b1011;
        e_seg = tab[h];
      end
      e_ft = (pos % F == 0) && (pos != 0);
      if (pos % F == F - 1 && m_pf) begin
        m_shown = m_pend;
        m_pf    = 1'b0;
      end
      if (bus.load) begin
        m_pend = bus.bcd_in;
        m_pf   = 1'b1;
      end
      e_pf = m_pf;
      pos++;
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      n_total++;
      if ({bus.an, bus.seg, bus.dp, bus.pending, bus.frame_tick} ===
          {e_an, e_seg, 1'b1, e_pf, e_ft})
        n_pass++;
      else
        $display("FAIL model pos=%0d got an=%b seg=%b dp=%b pend=%b ft=%b want an=%b seg=%b dp=1 pend=%b ft=%b",
                 pos, bus.an, bus.seg, bus.dp, bus.pending, bus.frame_tick,
                 e_an, e_seg, e_pf, e_ft);
    end
  end

  task automatic lit_disp(input string nm, input logic [3:0] a,
                          input logic [6:0] s);
    n_total++;
    if (bus.an === a && bus.seg === s)
      n_pass++;
    else
      $display("FAIL %s got an=%b seg=%b want an=%b seg=%b",
               nm, bus.an, bus.seg, a, s);
  endtask

  task automatic lit_bit(input string nm, input logic act, input logic exp);
    n_total++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s got %b want %b", nm, act, exp);
  endtask

  task automatic goto(input int p);
    int k;
    k = 0;
    while (pos != p && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (pos != p) begin
      n_total++;
      $display("FAIL goto_%0d got pos=%0d want %0d", p, pos, p);
    end
  endtask

  task automatic do_load(input logic [11:0] v);
    bus.load   = 1'b1;
    bus.bcd_in = v;
    @(negedge clk);
    bus.load   = 1'b0;
    bus.bcd_in = 12'($urandom);
  endtask

  initial begin
    reset      = 1'b1;
    bus.load   = 1'b0;
    bus.bcd_in = '0;
    repeat (2) @(negedge clk);
    lit_disp("rst_disp", 4'b1111, 7'b1111111);
    lit_bit("rst_pend", bus.pending, 1'b0);
    lit_bit("rst_ft", bus.frame_tick, 1'b0);
    lit_bit("rst_dp", bus.dp, 1'b1);
    reset = 1'b0;

    goto(1);  lit_disp("first_slot0", 4'b1110, 7'b1000000);
    goto(4);  lit_disp("slot0_last", 4'b1110, 7'b1000000);
    goto(5);  lit_disp("zero_tens_blank", 4'b1111, 7'b1111111);
    goto(16); lit_bit("ft_low_pre", bus.frame_tick, 1'b0);
    goto(17); lit_bit("ft_pulse", bus.frame_tick, 1'b1);
    goto(18); lit_bit("ft_single", bus.frame_tick, 1'b0);

    goto(20); do_load(12'h255);
    lit_bit("pend_rise", bus.pending, 1'b1);
    goto(31); lit_bit("pend_hold", bus.pending, 1'b1);
    goto(32); lit_bit("pend_fall", bus.pending, 1'b0);
    goto(33); lit_disp("v255_ones", 4'b1110, 7'b0010010);
    goto(37); lit_disp("v255_tens", 4'b1101, 7'b0010010);
    goto(41); lit_disp("v255_hund", 4'b1011, 7'b0100100);
    goto(45); lit_disp("v255_blank", 4'b1111, 7'b1111111);

    goto(48); do_load(12'h007);
    goto(65); lit_disp("v007_ones", 4'b1110, 7'b1111000);
    goto(69); lit_disp("v007_tens", 4'b1111, 7'b1111111);
    goto(73); lit_disp("v007_hund", 4'b1111, 7'b1111111);

    goto(80); do_load(12'h040);
    goto(97);  lit_disp("v040_ones", 4'b1110, 7'b1000000);
    goto(101); lit_disp("v040_tens", 4'b1101, 7'b0011001);
    goto(105); lit_disp("v040_hund", 4'b1111, 7'b1111111);

    goto(112); do_load(12'h1A3);
    goto(129); lit_disp("v1a3_ones", 4'b1110, 7'b0110000);
    goto(133); lit_disp("v1a3_dash", 4'b1101, 7'b0111111);
    goto(137); lit_disp("v1a3_hund", 4'b1011, 7'b1111001);

    goto(144); do_load(12'h111);
    goto(150); do_load(12'h222);
    goto(161); lit_disp("last_wins_ones", 4'b1110, 7'b0100100);
    goto(165); lit_disp("last_wins_tens", 4'b1101, 7'b0100100);
    goto(169); lit_disp("last_wins_hund", 4'b1011, 7'b0100100);

    goto(176); do_load(12'h333);
    goto(191); do_load(12'h444);
    lit_bit("bnd_load_pend", bus.pending, 1'b1);
    goto(193); lit_disp("bnd_prior_val", 4'b1110, 7'b0110000);
    goto(207); lit_bit("bnd_pend_hold", bus.pending, 1'b1);
    goto(208); lit_bit("bnd_pend_fall", bus.pending, 1'b0);
    goto(209); lit_disp("bnd_new_val", 4'b1110, 7'b0011001);

    goto(212); do_load(12'h555);
    goto(214);
    lit_bit("pre_rst_pend", bus.pending, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    lit_disp("mid_rst_disp", 4'b1111, 7'b1111111);
    lit_bit("mid_rst_pend", bus.pending, 1'b0);
    reset = 1'b0;
    goto(1);  lit_disp("post_rst_zero", 4'b1110, 7'b1000000);
    goto(5);  lit_disp("post_rst_tens", 4'b1111, 7'b1111111);
    goto(17); lit_bit("post_rst_ft", bus.frame_tick, 1'b1);
    goto(34); lit_disp("post_rst_kept0", 4'b1110, 7'b1000000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
